// File: rtl/axi_ic_pkg.sv
// Shared definitions for the AXI interconnect write path.
//   state_t           : write channel controller phase encoding
//   LEN_WIDTH_DEFAULT : default width of AWLEN and the beat counter
//   PORT0 / PORT1     : upstream port indices
package axi_ic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int LEN_WIDTH_DEFAULT = 8;

  localparam int PORT0 = 0;
  localparam int PORT1 = 1;

endpackage

// File: rtl/write_beat_counter.sv
// Remaining-beat counter for one write burst.
//   ACLK, ARESETN : clock, synchronous active-low reset
//   load          : capture load_value (AWLEN) at the AW handshake
//   load_value    : burst length minus 1
//   beat          : accepted W beat that is not the final one
//   zero          : counter has reached the last expected beat
module write_beat_counter #(
  parameter int Len_Width = 8
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic                 load,
  input  logic [Len_Width-1:0] load_value,
  input  logic                 beat,
  output logic                 zero
);

  logic [Len_Width-1:0] count;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (beat && (count != '0)) begin
      // Saturates at zero: an over-long burst never wraps the counter.
      count <= count - Len_Width'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/write_channel_controller.sv
// Shared AXI write path controller.
// Round-robin arbitration between S00 and S01; the grant is held for one full
// transaction (AW handshake, W beats through WLAST, B handshake).
//   ACLK, ARESETN            : clock, synchronous active-low reset
//   S0x_AXI_awvalid/awlen    : per-port address request and burst length-1
//   S0x_AXI_wvalid/wlast     : per-port write data valid and last beat
//   S0x_AXI_bready           : per-port response ready
//   M_AXI_awready/wready     : downstream AW / W ready
//   M_AXI_bvalid             : downstream response valid
//   Selected_Slave           : granted port, steers the AW/W/B muxes
//   AW_Enable/W_Enable/B_Enable : phase enables for the muxes
//   Channel_Busy             : transaction in progress
//   Burst_Error              : one-cycle pulse on WLAST / AWLEN mismatch
module write_channel_controller
  import axi_ic_pkg::*;
#(
  parameter int Len_Width      = LEN_WIDTH_DEFAULT,
  parameter int Slaves_ID_Size = 1
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic                      S00_AXI_awvalid,
  input  logic                      S01_AXI_awvalid,
  input  logic [Len_Width-1:0]      S00_AXI_awlen,
  input  logic [Len_Width-1:0]      S01_AXI_awlen,
  input  logic                      S00_AXI_wvalid,
  input  logic                      S01_AXI_wvalid,
  input  logic                      S00_AXI_wlast,
  input  logic                      S01_AXI_wlast,
  input  logic                      S00_AXI_bready,
  input  logic                      S01_AXI_bready,
  input  logic                      M_AXI_awready,
  input  logic                      M_AXI_wready,
  input  logic                      M_AXI_bvalid,
  output logic [Slaves_ID_Size-1:0] Selected_Slave,
  output logic                      AW_Enable,
  output logic                      W_Enable,
  output logic                      B_Enable,
  output logic                      Channel_Busy,
  output logic                      Burst_Error
);

  localparam logic [Slaves_ID_Size-1:0] P0 = Slaves_ID_Size'(PORT0);
  localparam logic [Slaves_ID_Size-1:0] P1 = Slaves_ID_Size'(PORT1);

  state_t                    state;
  logic [Slaves_ID_Size-1:0] last_grant;
  logic [Slaves_ID_Size-1:0] grant_port;

  logic                 sel_awvalid;
  logic [Len_Width-1:0] sel_awlen;
  logic                 sel_wvalid;
  logic                 sel_wlast;
  logic                 sel_bready;

  logic aw_hs;
  logic w_hs;
  logic beats_zero;
  logic beat_dec;

  // Per-port input mux driven by the registered grant.
  always_comb begin
    if (Selected_Slave == P0) begin
      sel_awvalid = S00_AXI_awvalid;
      sel_awlen   = S00_AXI_awlen;
      sel_wvalid  = S00_AXI_wvalid;
      sel_wlast   = S00_AXI_wlast;
      sel_bready  = S00_AXI_bready;
    end else begin
      sel_awvalid = S01_AXI_awvalid;
      sel_awlen   = S01_AXI_awlen;
      sel_wvalid  = S01_AXI_wvalid;
      sel_wlast   = S01_AXI_wlast;
      sel_bready  = S01_AXI_bready;
    end
  end

  // Round-robin: on contention the port that did not win last time goes next.
  always_comb begin
    grant_port = Selected_Slave;
    if (S00_AXI_awvalid && S01_AXI_awvalid) begin
      grant_port = (last_grant == P0) ? P1 : P0;
    end else if (S00_AXI_awvalid) begin
      grant_port = P0;
    end else if (S01_AXI_awvalid) begin
      grant_port = P1;
    end
  end

  assign aw_hs    = (state == ADDR) && sel_awvalid && M_AXI_awready;
  assign w_hs     = (state == DATA) && sel_wvalid && M_AXI_wready;
  assign beat_dec = w_hs && !beats_zero && !sel_wlast;

  write_beat_counter #(
    .Len_Width(Len_Width)
  ) u_beat_counter (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .load      (aw_hs),
    .load_value(sel_awlen),
    .beat      (beat_dec),
    .zero      (beats_zero)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state          <= IDLE;
      Selected_Slave <= P0;
      last_grant     <= P1;
      Burst_Error    <= 1'b0;
    end else begin
      Burst_Error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (S00_AXI_awvalid || S01_AXI_awvalid) begin
            Selected_Slave <= grant_port;
            state          <= ADDR;
          end
        end
        ADDR: begin
          if (aw_hs) state <= DATA;
        end
        DATA: begin
          // The beat ends the burst if either the count is exhausted or the
          // master says so; any disagreement between the two is an error.
          if (w_hs && (beats_zero || sel_wlast)) begin
            Burst_Error <= (beats_zero != sel_wlast);
            state       <= RESP;
          end
        end
        RESP: begin
          if (M_AXI_bvalid && sel_bready) begin
            last_grant <= Selected_Slave;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign AW_Enable    = (state == ADDR);
  assign W_Enable     = (state == DATA);
  assign B_Enable     = (state == RESP);
  assign Channel_Busy = (state != IDLE);

endmodule

// File: tb/tb_write_channel_controller.sv
// Directed bench for write_channel_controller with a transaction-level model.
module tb_write_channel_controller;

  logic       ACLK = 1'b0;
  logic       ARESETN = 1'b0;
  logic [1:0] awv = '0;
  logic [7:0] awl [2];
  logic [1:0] wv = '0;
  logic [1:0] wl = '0;
  logic [1:0] br = '0;
  logic       awready = 1'b0;
  logic       wready = 1'b0;
  logic       bvalid = 1'b0;

  logic [0:0] Selected_Slave;
  logic       AW_Enable, W_Enable, B_Enable, Channel_Busy, Burst_Error;

  int total = 0;
  int bad = 0;
  int err_pulses = 0;

  always #5 ACLK = ~ACLK;

  write_channel_controller #(
    .Len_Width(8),
    .Slaves_ID_Size(1)
  ) dut (
    .ACLK           (ACLK),
    .ARESETN        (ARESETN),
    .S00_AXI_awvalid(awv[0]),
    .S01_AXI_awvalid(awv[1]),
    .S00_AXI_awlen  (awl[0]),
    .S01_AXI_awlen  (awl[1]),
    .S00_AXI_wvalid (wv[0]),
    .S01_AXI_wvalid (wv[1]),
    .S00_AXI_wlast  (wl[0]),
    .S01_AXI_wlast  (wl[1]),
    .S00_AXI_bready (br[0]),
    .S01_AXI_bready (br[1]),
    .M_AXI_awready  (awready),
    .M_AXI_wready   (wready),
    .M_AXI_bvalid   (bvalid),
    .Selected_Slave (Selected_Slave),
    .AW_Enable      (AW_Enable),
    .W_Enable       (W_Enable),
    .B_Enable       (B_Enable),
    .Channel_Busy   (Channel_Busy),
    .Burst_Error    (Burst_Error)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // phase: 0 waiting for request, 1 address, 2 data, 3 response.
  // Beats are counted upward and compared against awlen+1.
  int m_phase = 0;
  int m_sel = 0;
  int m_last = 1;
  int m_len = 0;
  int m_beats = 0;
  int m_err = 0;
  bit m_valid = 0;

  always @(posedge ACLK) begin
    if (!ARESETN) begin
      m_phase = 0; m_sel = 0; m_last = 1; m_err = 0; m_beats = 0;
      m_valid = 1;
    end else begin
      m_err = 0;
      case (m_phase)
        0: if (awv != 2'b00) begin
             if (awv == 2'b11) m_sel = 1 - m_last;
             else m_sel = awv[1] ? 1 : 0;
             m_phase = 1;
           end
        1: if (awv[m_sel] && awready) begin
             m_len = int'(awl[m_sel]);
             m_beats = 0;
             m_phase = 2;
           end
        2: if (wv[m_sel] && wready) begin
             bit final_by_count;
             final_by_count = ((m_beats + 1) == (m_len + 1));
             m_beats++;
             if (wl[m_sel] || final_by_count) begin
               m_err = (wl[m_sel] != final_by_count) ? 1 : 0;
               m_phase = 3;
             end
           end
        3: if (bvalid && br[m_sel]) begin
             m_last = m_sel;
             m_phase = 0;
           end
        default: m_phase = 0;
      endcase
    end
  end

  // Compare every cycle once the model has seen reset.
  always @(negedge ACLK) begin
    if (m_valid) begin
      check("sel",   int'(Selected_Slave), m_sel);
      check("aw_en", int'(AW_Enable),      (m_phase == 1) ? 1 : 0);
      check("w_en",  int'(W_Enable),       (m_phase == 2) ? 1 : 0);
      check("b_en",  int'(B_Enable),       (m_phase == 3) ? 1 : 0);
      check("busy",  int'(Channel_Busy),   (m_phase != 0) ? 1 : 0);
      check("berr",  int'(Burst_Error),    m_err);
      if (Burst_Error) err_pulses++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_aw(output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (AW_Enable) begin ok = 1; break; end
    end
    if (!ok) check("aw_timeout", 0, 1);
  endtask

  // One complete transaction on port p. last_at = beat index carrying wlast
  // (-1 for none). keep_both leaves awvalid asserted after the AW handshake.
  task automatic txn(input int p, input int len, input int nbeats,
                     input int last_at, input bit keep_both,
                     input int aw_delay, input bit stall, input int exp_err);
    bit ok;
    err_pulses = 0;
    awl[p] = 8'(len);
    awv[p] = 1'b1;
    awready = 1'b0;
    wait_aw(ok);
    check("grant_port", int'(Selected_Slave), p);
    repeat (aw_delay) @(negedge ACLK);
    awready = 1'b1;
    @(negedge ACLK);
    awready = 1'b0;
    if (!keep_both) awv = 2'b00;
    wready = 1'b1;
    for (int i = 0; i < nbeats; i++) begin
      if (stall && i == 1) begin
        wready = 1'b0; wv[p] = 1'b1; wl[p] = 1'b0;
        @(negedge ACLK);
        wready = 1'b1;
      end
      wv[p] = 1'b1;
      wl[p] = (i == last_at);
      @(negedge ACLK);
    end
    wv = 2'b00; wl = 2'b00; wready = 1'b0;
    bvalid = 1'b1; br[p] = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (B_Enable) begin ok = 1; break; end
      @(negedge ACLK);
    end
    if (!ok) check("b_timeout", 0, 1);
    @(negedge ACLK);
    bvalid = 1'b0; br = 2'b00;
    check("burst_err_pulses", err_pulses, exp_err);
  endtask

  initial begin
    bit ok;
    awl[0] = '0; awl[1] = '0;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_sel", int'(Selected_Slave), 0);
    check("rst_busy", int'(Channel_Busy), 0);
    ARESETN = 1'b1;
    @(negedge ACLK);

    // Basic 4-beat burst on S00, with AW backpressure and a W stall.
    txn(0, 3, 4, 3, 1'b0, 2, 1'b1, 0);
    @(negedge ACLK);
    // Single-beat burst on S01.
    txn(1, 0, 1, 0, 1'b0, 0, 1'b0, 0);
    @(negedge ACLK);
    // Both ports requesting: grants must alternate 0, 1, 0.
    awl[0] = 8'd1; awl[1] = 8'd2;
    awv = 2'b11;
    txn(0, 1, 2, 1, 1'b1, 0, 1'b0, 0);
    txn(1, 2, 3, 2, 1'b1, 1, 1'b0, 0);
    txn(0, 1, 2, 1, 1'b0, 0, 1'b0, 0);
    @(negedge ACLK);
    // Early wlast on beat 2 of a 4-beat burst.
    txn(0, 3, 2, 1, 1'b0, 0, 1'b0, 1);
    @(negedge ACLK);
    // Missing wlast on the final beat of a 2-beat burst.
    txn(0, 1, 2, -1, 1'b0, 0, 1'b0, 1);
    @(negedge ACLK);

    // Reset in the middle of a port-1 data phase.
    awl[1] = 8'd3; awv[1] = 1'b1; awready = 1'b1;
    wait_aw(ok);
    check("mid_grant", int'(Selected_Slave), 1);
    @(negedge ACLK);
    awv = 2'b00; awready = 1'b0;
    wv[1] = 1'b1; wl[1] = 1'b0; wready = 1'b1;
    @(negedge ACLK);
    check("mid_in_data", int'(W_Enable), 1);
    wv = 2'b00; wready = 1'b0;
    ARESETN = 1'b0;
    @(negedge ACLK);
    check("rst_w_en", int'(W_Enable), 0);
    check("rst_busy2", int'(Channel_Busy), 0);
    check("rst_sel2", int'(Selected_Slave), 0);
    ARESETN = 1'b1;
    awl[0] = 8'd0; awl[1] = 8'd0;
    awv = 2'b11;
    wait_aw(ok);
    check("post_rst_grant", int'(Selected_Slave), 0);
    awv = 2'b00;
    repeat (3) @(negedge ACLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
